phold_engine: RTL and testbench



---
 rtl/phold_engine.sv | 198 +++++++++++++++++++
 tb/tb_phold_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/phold_engine.sv
// phold_engine: sequential PHOLD event engine; pops min-time events, does RMW traffic on MC port 0,
// schedules LFSR-driven future events and reports GVT plus run statistics.
module phold_engine #(
    parameter int NUM_MC_PORTS    = 16,
    parameter int MC_RTNCTL_WIDTH = 32
) (
    input  logic                                    clk,
    input  logic                                    i_reset,
    input  logic [15:0]                             sim_end,
    input  logic [47:0]                             addr,
    input  logic [8:0]                              num_init_events,
    input  logic [7:0]                              lp_mask,
    input  logic [3:0]                              num_memcall,
    output logic [15:0]                             gvt,
    output logic                                    rtn_vld,
    output logic                                    cleanup,
    output logic [NUM_MC_PORTS-1:0]                 mc_rq_vld,
    output logic [3*NUM_MC_PORTS-1:0]               mc_rq_cmd,
    output logic [4*NUM_MC_PORTS-1:0]               mc_rq_scmd,
    output logic [48*NUM_MC_PORTS-1:0]              mc_rq_vadr,
    output logic [2*NUM_MC_PORTS-1:0]               mc_rq_size,
    output logic [MC_RTNCTL_WIDTH*NUM_MC_PORTS-1:0] mc_rq_rtnctl,
    output logic [64*NUM_MC_PORTS-1:0]              mc_rq_data,
    output logic [NUM_MC_PORTS-1:0]                 mc_rq_flush,
    input  logic [NUM_MC_PORTS-1:0]                 mc_rq_stall,
    input  logic [NUM_MC_PORTS-1:0]                 mc_rs_vld,
    input  logic [3*NUM_MC_PORTS-1:0]               mc_rs_cmd,
    input  logic [4*NUM_MC_PORTS-1:0]               mc_rs_scmd,
    input  logic [64*NUM_MC_PORTS-1:0]              mc_rs_data,
    input  logic [MC_RTNCTL_WIDTH*NUM_MC_PORTS-1:0] mc_rs_rtnctl,
    output logic [NUM_MC_PORTS-1:0]                 mc_rs_stall,
    input  logic [NUM_MC_PORTS-1:0]                 mc_rs_flush_cmplt,
    output logic [63:0]                             total_cycles,
    output logic [63:0]                             total_events,
    output logic [63:0]                             total_stalls,
    output logic [63:0]                             total_antimsg,
    output logic [63:0]                             total_q_conf,
    output logic [63:0]                             avg_proc_time,
    output logic [63:0]                             avg_mem_time
);
    localparam int NP = NUM_MC_PORTS;

    typedef enum logic [3:0] {INIT, POP, RD, RDW, WR, WRW, PUSH, DIV, DONE} state_t;

    state_t       state, nxt;
    logic         rst_q;
    logic [15:0]  q_time [32];
    logic [7:0]   q_lp [32];
    logic [31:0]  q_vld;
    logic [5:0]   init_cnt, n_init;
    logic [4:0]   slot, min_idx;
    logic [15:0]  ev_time, min_time, lfsr, gvt_r;
    logic [7:0]   ev_lp;
    logic [3:0]   mc_cnt;
    logic [6:0]   div_cnt;
    logic [63:0]  rd_data, div_q, div_r, cyc, events, stalls, mem_cyc, q_conf, avg_proc, avg_mem;
    logic [63:0]  div_src, dq_in, r_in, dq_nxt;
    logic [64:0]  r_sh, r_sub;
    logic         min_hit, div_ge, rd_rsp, wr_rsp, rtn_r, clean_r, unused_ok;

    assign n_init = (num_init_events > 9'd32) ? 6'd32 : num_init_events[5:0];
    assign rd_rsp = mc_rs_vld[0] && mc_rs_cmd[2:0] == 3'd2;
    assign wr_rsp = mc_rs_vld[0] && mc_rs_cmd[2:0] == 3'd3;

    // Scan upward with strict compare so ties resolve to the lowest index
    always_comb begin
        min_hit  = 1'b0;
        min_idx  = '0;
        min_time = '0;
        for (int i = 0; i < 32; i++)
            if (q_vld[i] && (!min_hit || q_time[i] < min_time)) begin
                min_hit  = 1'b1;
                min_idx  = 5'(i);
                min_time = q_time[i];
            end
    end

    // One restoring-division step per DIV cycle; each 64-step quotient restarts from its own dividend
    assign div_src = div_cnt[6] ? mem_cyc : cyc;
    assign dq_in   = (div_cnt[5:0] == 6'd0) ? div_src : div_q;
    assign r_in    = (div_cnt[5:0] == 6'd0) ? '0 : div_r;
    assign r_sh    = {r_in, dq_in[63]};
    assign r_sub   = r_sh - {1'b0, events};
    assign div_ge  = r_sh >= {1'b0, events};
    assign dq_nxt  = {dq_in[62:0], div_ge};

    always_ff @(posedge clk) rst_q <= i_reset;

    always_ff @(posedge clk)
        if (rst_q) state <= INIT;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            INIT: nxt = (init_cnt + 6'd1 >= n_init) ? POP : INIT;
            POP:  nxt = (!min_hit || min_time >= sim_end) ? DIV : (num_memcall == 4'd0 ? PUSH : RD);
            RD:   nxt = mc_rq_stall[0] ? RD : RDW;
            RDW:  nxt = rd_rsp ? WR : RDW;
            WR:   nxt = mc_rq_stall[0] ? WR : WRW;
            WRW:  nxt = wr_rsp ? (mc_cnt + 4'd1 == num_memcall ? PUSH : RD) : WRW;
            PUSH: nxt = POP;
            DIV:  nxt = (div_cnt == 7'd127) ? DONE : DIV;
            DONE: nxt = DONE;
            default: nxt = INIT;
        endcase
    end

    always_comb begin
        mc_rq_vld    = '0;
        mc_rq_cmd    = '0;
        mc_rq_scmd   = '0;
        mc_rq_vadr   = '0;
        mc_rq_size   = '0;
        mc_rq_rtnctl = '0;
        mc_rq_data   = '0;
        mc_rq_vld[0]      = !rst_q && (state == RD || state == WR);
        mc_rq_cmd[2:0]    = (state == WR) ? 3'd2 : 3'd1;
        mc_rq_size[1:0]   = 2'd3;
        mc_rq_vadr[47:0]  = addr + {37'b0, ev_lp, 3'b000};
        mc_rq_data[63:0]  = rd_data + 64'd1;
    end

    always_ff @(posedge clk)
        if (rst_q) begin
            for (int i = 0; i < 32; i++) begin
                q_time[i] <= '0;
                q_lp[i]   <= '0;
            end
            q_vld <= '0; init_cnt <= '0; slot <= '0; ev_time <= '0; ev_lp <= '0;
            mc_cnt <= '0; rd_data <= '0; lfsr <= 16'hACE1; div_cnt <= '0; div_q <= '0; div_r <= '0;
            cyc <= '0; events <= '0; stalls <= '0; mem_cyc <= '0; q_conf <= '0;
            avg_proc <= '0; avg_mem <= '0; gvt_r <= '0; rtn_r <= 1'b0; clean_r <= 1'b0;
        end else begin
            rtn_r <= 1'b0;
            if (state != DIV && state != DONE) cyc <= cyc + 64'd1;
            if (mc_rq_vld[0] && mc_rq_stall[0]) stalls <= stalls + 64'd1;
            if (state inside {RD, RDW, WR, WRW}) mem_cyc <= mem_cyc + 64'd1;
            case (state)
                INIT: begin
                    if (init_cnt < n_init) begin
                        q_time[init_cnt[4:0]] <= '0;
                        q_lp[init_cnt[4:0]]   <= {2'b00, init_cnt} & lp_mask;
                        q_vld[init_cnt[4:0]]  <= 1'b1;
                    end
                    init_cnt <= init_cnt + 6'd1;
                    q_conf   <= (num_init_events > 9'd32) ? 64'(num_init_events - 9'd32) : '0;
                end
                POP:
                    if (!min_hit) gvt_r <= '0;
                    else if (min_time >= sim_end) gvt_r <= min_time;
                    else begin
                        q_vld[min_idx] <= 1'b0;
                        slot    <= min_idx;
                        ev_time <= min_time;
                        ev_lp   <= q_lp[min_idx];
                        events  <= events + 64'd1;
                        mc_cnt  <= '0;
                    end
                RDW: if (rd_rsp) rd_data <= mc_rs_data[63:0];
                WRW: if (wr_rsp) mc_cnt <= mc_cnt + 4'd1;
                PUSH: begin
                    q_time[slot] <= ev_time + {12'b0, lfsr[3:0]} + 16'd1;
                    q_lp[slot]   <= lfsr[15:8] & lp_mask;
                    q_vld[slot]  <= 1'b1;
                    lfsr         <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
                end
                DIV: begin
                    div_q   <= dq_nxt;
                    div_r   <= div_ge ? r_sub[63:0] : r_sh[63:0];
                    div_cnt <= div_cnt + 7'd1;
                    if (div_cnt == 7'd63) avg_proc <= (events == '0) ? '0 : dq_nxt;
                    if (div_cnt == 7'd127) begin
                        avg_mem <= (events == '0) ? '0 : dq_nxt;
                        rtn_r   <= 1'b1;
                        clean_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end

    // Outputs read zero as soon as the registered reset is seen, before the state clears
    assign gvt           = rst_q ? '0 : gvt_r;
    assign rtn_vld       = !rst_q && rtn_r;
    assign cleanup       = !rst_q && clean_r;
    assign total_cycles  = rst_q ? '0 : cyc;
    assign total_events  = rst_q ? '0 : events;
    assign total_stalls  = rst_q ? '0 : stalls;
    assign total_antimsg = '0;
    assign total_q_conf  = rst_q ? '0 : q_conf;
    assign avg_proc_time = rst_q ? '0 : avg_proc;
    assign avg_mem_time  = rst_q ? '0 : avg_mem;
    assign mc_rq_flush   = '0;
    assign mc_rs_stall   = '0;
    assign unused_ok     = ^{mc_rs_vld[NP-1:1], mc_rs_cmd[3*NP-1:3], mc_rs_scmd, mc_rs_data[64*NP-1:64],
                             mc_rs_rtnctl, mc_rq_stall[NP-1:1], mc_rs_flush_cmplt};
endmodule

// File: tb/tb_phold_engine.sv
// tb_phold_engine: directed checks of phold_engine against a port-0 memory responder model.
module tb_phold_engine;
    localparam int NP = 16;
    localparam int RW = 32;

    logic               clk = 1'b0;
    logic               i_reset = 1'b1;
    logic [15:0]        sim_end = '0;
    logic [47:0]        addr = '0;
    logic [8:0]         num_init_events = '0;
    logic [7:0]         lp_mask = '0;
    logic [3:0]         num_memcall = '0;
    logic [15:0]        gvt;
    logic               rtn_vld, cleanup;
    logic [NP-1:0]      mc_rq_vld, mc_rq_flush, mc_rs_stall;
    logic [3*NP-1:0]    mc_rq_cmd;
    logic [4*NP-1:0]    mc_rq_scmd;
    logic [48*NP-1:0]   mc_rq_vadr;
    logic [2*NP-1:0]    mc_rq_size;
    logic [RW*NP-1:0]   mc_rq_rtnctl;
    logic [64*NP-1:0]   mc_rq_data;
    logic [NP-1:0]      mc_rq_stall = '0, mc_rs_vld = '0, mc_rs_flush_cmplt = '0;
    logic [3*NP-1:0]    mc_rs_cmd = '0;
    logic [4*NP-1:0]    mc_rs_scmd = '0;
    logic [64*NP-1:0]   mc_rs_data = '0;
    logic [RW*NP-1:0]   mc_rs_rtnctl = '0;
    logic [63:0]        total_cycles, total_events, total_stalls, total_antimsg, total_q_conf;
    logic [63:0]        avg_proc_time, avg_mem_time;

    int n_chk = 0, n_pass = 0;
    int stall_arm = 0, stall_left = 0, stall_cycles = 0, stall_moved = 0;
    int n_vld = 0, other_vld = 0, bad_fields = 0;
    logic [63:0] preload = '0, pend_data = '0;
    logic [63:0] mem [256];
    logic        pend = 1'b0;
    logic [2:0]  pend_cmd = '0, snap_cmd = '0;
    logic [47:0] snap_vadr = '0, off = '0;
    logic [7:0]  idx = '0;
    logic [2:0]  cmd_log [$];
    logic [47:0] adr_log [$];
    logic [63:0] wr_log [$];

    phold_engine #(.NUM_MC_PORTS(NP), .MC_RTNCTL_WIDTH(RW)) dut (
        .clk(clk), .i_reset(i_reset), .sim_end(sim_end), .addr(addr),
        .num_init_events(num_init_events), .lp_mask(lp_mask), .num_memcall(num_memcall),
        .gvt(gvt), .rtn_vld(rtn_vld), .cleanup(cleanup),
        .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd), .mc_rq_vadr(mc_rq_vadr),
        .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl), .mc_rq_data(mc_rq_data),
        .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall), .mc_rs_vld(mc_rs_vld),
        .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd), .mc_rs_data(mc_rs_data),
        .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_stall(mc_rs_stall), .mc_rs_flush_cmplt(mc_rs_flush_cmplt),
        .total_cycles(total_cycles), .total_events(total_events), .total_stalls(total_stalls),
        .total_antimsg(total_antimsg), .total_q_conf(total_q_conf),
        .avg_proc_time(avg_proc_time), .avg_mem_time(avg_mem_time)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Memory responds one cycle after accepting a request; stalls only reads, for stall_arm cycles
    always @(negedge clk)
        if (i_reset) begin
            mc_rs_vld = '0; mc_rq_stall = '0; pend = 1'b0; stall_left = stall_arm;
            stall_cycles = 0; stall_moved = 0; n_vld = 0; other_vld = 0; bad_fields = 0;
            cmd_log.delete(); adr_log.delete(); wr_log.delete();
            for (int i = 0; i < 256; i++) mem[i] = preload;
        end else begin
            mc_rs_vld = '0;
            if (pend) begin
                mc_rs_vld[0] = 1'b1; mc_rs_cmd[2:0] = pend_cmd; mc_rs_data[63:0] = pend_data; pend = 1'b0;
            end
            if (mc_rq_vld[NP-1:1] != '0) other_vld++;
            if (mc_rq_flush != '0 || mc_rs_stall != '0) bad_fields++;
            if (mc_rq_vld[0]) n_vld++;
            mc_rq_stall[0] = mc_rq_vld[0] && mc_rq_cmd[2:0] == 3'd1 && stall_left > 0;
            if (mc_rq_stall[0]) begin
                if (stall_cycles == 0) begin
                    snap_vadr = mc_rq_vadr[47:0]; snap_cmd = mc_rq_cmd[2:0];
                end else if (mc_rq_vadr[47:0] != snap_vadr || mc_rq_cmd[2:0] != snap_cmd) stall_moved++;
                stall_cycles++;
                stall_left--;
            end else if (mc_rq_vld[0]) begin
                off = mc_rq_vadr[47:0] - addr;
                idx = off[10:3];
                if (mc_rq_size[1:0] != 2'd3 || mc_rq_scmd[3:0] != 4'd0 || mc_rq_rtnctl[RW-1:0] != '0) bad_fields++;
                cmd_log.push_back(mc_rq_cmd[2:0]);
                adr_log.push_back(mc_rq_vadr[47:0]);
                if (mc_rq_cmd[2:0] == 3'd2) begin
                    mem[idx] = mc_rq_data[63:0]; wr_log.push_back(mc_rq_data[63:0]);
                    pend_cmd = 3'd3; pend_data = '0;
                end else begin
                    pend_cmd = 3'd2; pend_data = mem[idx];
                end
                pend = 1'b1;
            end
        end

    task automatic reset_checks(input string tag);
        check({tag, "_gvt"}, gvt, 0);
        check({tag, "_rtn"}, rtn_vld, 0);
        check({tag, "_cleanup"}, cleanup, 0);
        check({tag, "_rq_vld"}, mc_rq_vld, 0);
        check({tag, "_cycles"}, total_cycles, 0);
        check({tag, "_events"}, total_events, 0);
        check({tag, "_stalls"}, total_stalls, 0);
        check({tag, "_qconf"}, total_q_conf, 0);
        check({tag, "_avgp"}, avg_proc_time, 0);
        check({tag, "_avgm"}, avg_mem_time, 0);
    endtask

    task automatic start(input logic [15:0] se, input logic [8:0] n, input logic [7:0] m,
                         input logic [3:0] mc, input logic [47:0] a, input logic [63:0] pre, input int st);
        @(negedge clk);
        sim_end = se; num_init_events = n; lp_mask = m; num_memcall = mc; addr = a;
        preload = pre; stall_arm = st; i_reset = 1'b1;
        repeat (3) @(negedge clk);
        reset_checks("rst");
        i_reset = 1'b0;
    endtask

    task automatic wait_done();
        int c = 0;
        while (rtn_vld !== 1'b1 && c < 4000) begin
            @(negedge clk);
            c++;
        end
        check("done_seen", rtn_vld, 1);
        check("antimsg", total_antimsg, 0);
        check("other_ports", other_vld, 0);
        check("bus_fields", bad_fields, 0);
    endtask

    task automatic pulse_check();
        @(negedge clk);
        check("rtn_pulse_end", rtn_vld, 0);
        check("cleanup_hold", cleanup, 1);
    endtask

    initial begin
        // Empty queue: straight to DIV with zero results
        start(16'd100, 9'd0, 8'hFF, 4'd1, 48'h0, 64'd0, 0);
        wait_done();
        check("e0_gvt", gvt, 0);
        check("e0_events", total_events, 0);
        check("e0_avgp", avg_proc_time, 0);
        check("e0_avgm", avg_mem_time, 0);
        check("e0_no_rq", n_vld, 0);
        pulse_check();

        // First popped event already at sim_end=0; INIT 4 + POP 1
        start(16'd0, 9'd4, 8'hFF, 4'd3, 48'h0, 64'd0, 0);
        wait_done();
        check("se0_gvt", gvt, 0);
        check("se0_events", total_events, 0);
        check("se0_cycles", total_cycles, 5);
        check("se0_no_rq", n_vld, 0);
        pulse_check();

        // One event, no memcalls: delta = 1 + 16'hACE1[3:0] = 2; INIT, POP, PUSH, POP = 4 cycles
        start(16'd1, 9'd1, 8'h00, 4'd0, 48'h0, 64'd0, 0);
        wait_done();
        check("one_gvt", gvt, 2);
        check("one_events", total_events, 1);
        check("one_cycles", total_cycles, 4);
        check("one_avgp", avg_proc_time, 4);
        check("one_avgm", avg_mem_time, 0);
        check("one_no_rq", n_vld, 0);

        // Two RMWs per event; times 0 -> 2 -> 3 (second LFSR value 16'h5670 gives delta 1)
        start(16'd3, 9'd1, 8'h00, 4'd2, 48'h1000, 64'd5, 0);
        wait_done();
        check("rmw_gvt", gvt, 3);
        check("rmw_events", total_events, 2);
        check("rmw_nreq", cmd_log.size(), 8);
        for (int i = 0; i < cmd_log.size() && i < 8; i++) begin
            check("rmw_cmd", cmd_log[i], (i % 2 == 1) ? 3'd2 : 3'd1);
            check("rmw_vadr", adr_log[i], 48'h1000);
        end
        check("rmw_nwr", wr_log.size(), 4);
        for (int i = 0; i < wr_log.size() && i < 4; i++) check("rmw_wdata", wr_log[i], 64'(6 + i));
        check("rmw_mem", mem[0], 9);
        check("rmw_cycles", total_cycles, 22);
        check("rmw_avgp", avg_proc_time, 11);
        check("rmw_avgm", avg_mem_time, 8);
        check("rmw_stalls", total_stalls, 0);

        // Read stalled 10 cycles: RD lasts 11, total 18 cycles, 14 of them in memory states
        start(16'd1, 9'd1, 8'h00, 4'd1, 48'h2000, 64'd5, 10);
        wait_done();
        check("stl_stalls", total_stalls, 10);
        check("stl_seen", stall_cycles, 10);
        check("stl_hold", stall_moved, 0);
        check("stl_gvt", gvt, 2);
        check("stl_cycles", total_cycles, 18);
        check("stl_avgm", avg_mem_time, 14);
        check("stl_avgp", avg_proc_time, 18);
        check("stl_wdata", (wr_log.size() > 0) ? wr_log[0] : 64'hDEAD, 6);

        // Oversized init count saturates; reset mid-run clears outputs on the next cycle
        start(16'd1000, 9'd40, 8'hFF, 4'd1, 48'h0, 64'd0, 0);
        repeat (40) @(negedge clk);
        check("big_qconf", total_q_conf, 8);
        check("big_running", rtn_vld, 0);
        check("big_progress", total_events != 0, 1);
        i_reset = 1'b1;
        @(negedge clk);
        reset_checks("mid");
        repeat (2) @(negedge clk);
        i_reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
